// File: rtl/idx_encode_unit.sv
// Registered index encoders: first-set-bit search (trailing or leading zero count)
// and one-hot-to-binary conversion, sharing one valid and one output register stage.
module idx_encode_unit #(
  parameter int WIDTH = 8,
  parameter int MODE  = 0,
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] lzc_in_i,
  input  logic [WIDTH-1:0] onehot_i,
  output logic             valid_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] bin_o,
  output logic             multi_hot_o
);

  logic [CNT_W-1:0] cnt_next;
  logic             empty_next;
  logic [CNT_W-1:0] bin_next;
  logic             multi_hot_next;

  logic             valid_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             empty_reg;
  logic [CNT_W-1:0] bin_reg;
  logic             multi_hot_reg;

  // Each set one-hot bit contributes its own index; the OR of all terms is bin.
  logic [CNT_W-1:0] idx_term [WIDTH];

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_idx_term
      assign idx_term[gi] = onehot_i[gi] ? CNT_W'(gi) : '0;
    end
  endgenerate

  // Priority search: the last matching iteration wins, so the scan order
  // selects the lowest (MODE 0) or highest (MODE 1) set bit.
  always_comb begin
    cnt_next   = '0;
    empty_next = 1'b1;
    if (MODE == 0) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (lzc_in_i[i]) begin
          cnt_next   = CNT_W'(i);
          empty_next = 1'b0;
        end
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (lzc_in_i[i]) begin
          cnt_next   = CNT_W'(WIDTH - 1 - i);
          empty_next = 1'b0;
        end
      end
    end
  end

  always_comb begin
    logic seen_one;
    bin_next       = '0;
    multi_hot_next = 1'b0;
    seen_one       = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      bin_next = bin_next | idx_term[i];
      if (onehot_i[i]) begin
        if (seen_one) begin
          multi_hot_next = 1'b1;
        end
        seen_one = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_reg     <= 1'b0;
      cnt_reg       <= '0;
      empty_reg     <= 1'b1;
      bin_reg       <= '0;
      multi_hot_reg <= 1'b0;
    end else begin
      valid_reg <= valid_i;
      if (valid_i) begin
        cnt_reg       <= cnt_next;
        empty_reg     <= empty_next;
        bin_reg       <= bin_next;
        multi_hot_reg <= multi_hot_next;
      end
    end
  end

  assign valid_o     = valid_reg;
  assign cnt_o       = cnt_reg;
  assign empty_o     = empty_reg;
  assign bin_o       = bin_reg;
  assign multi_hot_o = multi_hot_reg;

endmodule

// File: tb/tb_idx_encode_unit.sv
// Directed bench for idx_encode_unit: three instances (trailing/8, leading/8, trailing/5)
// driven in lockstep, each output checked against hand-computed values.
module tb_idx_encode_unit;

  logic       clk;
  logic       rst_n;
  logic       valid;
  logic [7:0] a_lzc, a_oh;
  logic [7:0] b_lzc, b_oh;
  logic [4:0] c_lzc, c_oh;

  logic       a_valid, a_empty, a_multi;
  logic [2:0] a_cnt, a_bin;
  logic       b_valid, b_empty, b_multi;
  logic [2:0] b_cnt, b_bin;
  logic       c_valid, c_empty, c_multi;
  logic [2:0] c_cnt, c_bin;

  int vectors;
  int miscompares;

  idx_encode_unit #(.WIDTH(8), .MODE(0)) u_tz8 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid),
    .lzc_in_i(a_lzc), .onehot_i(a_oh),
    .valid_o(a_valid), .cnt_o(a_cnt), .empty_o(a_empty),
    .bin_o(a_bin), .multi_hot_o(a_multi)
  );

  idx_encode_unit #(.WIDTH(8), .MODE(1)) u_lz8 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid),
    .lzc_in_i(b_lzc), .onehot_i(b_oh),
    .valid_o(b_valid), .cnt_o(b_cnt), .empty_o(b_empty),
    .bin_o(b_bin), .multi_hot_o(b_multi)
  );

  idx_encode_unit #(.WIDTH(5), .MODE(0)) u_tz5 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid),
    .lzc_in_i(c_lzc), .onehot_i(c_oh),
    .valid_o(c_valid), .cnt_o(c_cnt), .empty_o(c_empty),
    .bin_o(c_bin), .multi_hot_o(c_multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic step(input logic v);
    valid = v;
    @(posedge clk);
    #1;
    $display("t=%0t valid=%0b a_lzc=%h a_oh=%h b_lzc=%h c_lzc=%h c_oh=%h | a_cnt=%0d a_bin=%0d b_cnt=%0d c_cnt=%0d c_bin=%0d",
             $time, v, a_lzc, a_oh, b_lzc, c_lzc, c_oh, a_cnt, a_bin, b_cnt, c_cnt, c_bin);
    @(negedge clk);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b0;
    valid = 1'b0;
    a_lzc = '0; a_oh = '0;
    b_lzc = '0; b_oh = '0;
    c_lzc = '0; c_oh = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(a_valid), 32'd0);
    chk("rst_empty", 32'(a_empty), 32'd1);
    chk("rst_cnt",   32'(a_cnt),   32'd0);
    chk("rst_bin",   32'(a_bin),   32'd0);
    chk("rst_multi", 32'(a_multi), 32'd0);

    rst_n = 1'b1;
    @(negedge clk);
    // Load non-reset values, then reset asynchronously while valid is still high.
    a_lzc = 8'hA8; a_oh = 8'h06;
    step(1'b1);
    chk("pre_rst_cnt", 32'(a_cnt), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(a_valid), 32'd0);
    chk("mid_rst_empty", 32'(a_empty), 32'd1);
    chk("mid_rst_cnt",   32'(a_cnt),   32'd0);
    chk("mid_rst_bin",   32'(a_bin),   32'd0);
    chk("mid_rst_multi", 32'(a_multi), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    a_lzc = 8'h04; a_oh = 8'h00;
    step(1'b1);
    chk("post_rst_valid", 32'(a_valid), 32'd1);
    chk("post_rst_cnt",   32'(a_cnt),   32'd2);

    a_lzc = 8'hA8; b_lzc = 8'h16;
    step(1'b1);
    chk("tz_a8_cnt",   32'(a_cnt),   32'd3);
    chk("tz_a8_empty", 32'(a_empty), 32'd0);
    chk("lz_16_cnt",   32'(b_cnt),   32'd3);
    a_lzc = 8'h01; b_lzc = 8'h80;
    step(1'b1);
    chk("tz_01_cnt", 32'(a_cnt), 32'd0);
    chk("lz_80_cnt", 32'(b_cnt), 32'd0);
    a_lzc = 8'h80; b_lzc = 8'h01;
    step(1'b1);
    chk("tz_80_cnt", 32'(a_cnt), 32'd7);
    chk("lz_01_cnt", 32'(b_cnt), 32'd7);
    a_lzc = 8'h00; b_lzc = 8'h00;
    step(1'b1);
    chk("tz_00_empty", 32'(a_empty), 32'd1);
    chk("tz_00_cnt",   32'(a_cnt),   32'd0);
    chk("lz_00_empty", 32'(b_empty), 32'd1);
    chk("lz_00_cnt",   32'(b_cnt),   32'd0);

    for (int k = 0; k < 8; k++) begin
      a_oh = 8'(1 << k);
      step(1'b1);
      chk("oh_sweep_bin",   32'(a_bin),   32'(k));
      chk("oh_sweep_multi", 32'(a_multi), 32'd0);
    end
    a_oh = 8'h06;
    step(1'b1);
    chk("oh_06_bin",   32'(a_bin),   32'd3);
    chk("oh_06_multi", 32'(a_multi), 32'd1);
    chk("oh_06_cnt_indep", 32'(a_cnt), 32'd0);
    a_oh = 8'h00;
    step(1'b1);
    chk("oh_00_bin",   32'(a_bin),   32'd0);
    chk("oh_00_multi", 32'(a_multi), 32'd0);

    a_lzc = 8'h02;
    step(1'b1);
    chk("b2b_first_cnt", 32'(a_cnt), 32'd1);
    a_lzc = 8'h10;
    step(1'b1);
    chk("b2b_second_cnt",   32'(a_cnt),   32'd4);
    chk("b2b_second_valid", 32'(a_valid), 32'd1);
    a_lzc = 8'hFF; a_oh = 8'h80;
    step(1'b0);
    chk("hold_cnt",   32'(a_cnt),   32'd4);
    chk("hold_valid", 32'(a_valid), 32'd0);
    chk("hold_bin",   32'(a_bin),   32'd0);

    c_lzc = 5'b10000; c_oh = 5'b10000;
    step(1'b1);
    chk("w5_cnt",   32'(c_cnt),   32'd4);
    chk("w5_bin",   32'(c_bin),   32'd4);
    chk("w5_empty", 32'(c_empty), 32'd0);
    c_lzc = 5'b01100; c_oh = 5'b00111;
    step(1'b1);
    chk("w5_cnt_2",  32'(c_cnt),   32'd2);
    chk("w5_bin_or", 32'(c_bin),   32'd3);
    chk("w5_multi",  32'(c_multi), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
